// File: rtl/tia_lfsr_pkg.sv
// Shared constants and LFSR helpers for the TIA-style LFSR sequencer.
// lfsr_next  : one XNOR-feedback step of a width-bit LFSR.
// lfsr_step  : state reached after n steps starting from 0.
// period_ok  : true when no state 1..period-1 steps from 0 returns to 0,
//              and width/period are inside the supported range.
package tia_lfsr_pkg;

    localparam int         TIA_W      = 6;
    localparam logic [5:0] TIA_TAPS   = 6'b110000;
    localparam int         TIA_PERIOD = 57;

    function automatic logic [15:0] lfsr_next(input int width,
                                              input logic [15:0] taps,
                                              input logic [15:0] s);
        logic [15:0] mask;
        mask = 16'((32'd1 << width) - 32'd1);
        return ((s << 1) | {15'd0, ~^(s & taps & mask)}) & mask;
    endfunction

    function automatic logic [15:0] lfsr_step(input int width,
                                              input logic [15:0] taps,
                                              input int n);
        logic [15:0] s;
        s = '0;
        for (int i = 0; i < n; i++) s = lfsr_next(width, taps, s);
        return s;
    endfunction

    function automatic bit period_ok(input int width,
                                     input logic [15:0] taps,
                                     input int period);
        logic [15:0] s;
        bit          ok;
        ok = (width >= 3) && (width <= 16) && (period >= 2) &&
             (period <= (1 << width) - 1);
        s = '0;
        if (ok) begin
            for (int k = 1; k < period; k++) begin
                s = lfsr_next(width, taps, s);
                if (s == '0) ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/tia_lfsr_channel.sv
// One programmable decode channel of the LFSR sequencer.
// Ports:
//   clk, rstl          clock, async active-low reset
//   we                 load match/en/os from cfg_* and re-arm
//   cfg_val/en/os      configuration data
//   adv                sequencer advance; a one-shot only disarms when the
//                      state actually moves on past its match
//   state              current LFSR state
//   hit                en & armed & (state == match)
module tia_lfsr_channel #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rstl,
    input  logic         we,
    input  logic [W-1:0] cfg_val,
    input  logic         cfg_en,
    input  logic         cfg_os,
    input  logic         adv,
    input  logic [W-1:0] state,
    output logic         hit
);

    logic [W-1:0] match_q;
    logic         en_q;
    logic         os_q;
    logic         armed_q;

    assign hit = en_q & armed_q & (state == match_q);

    always_ff @(posedge clk or negedge rstl) begin
        if (!rstl) begin
            match_q <= '0;
            en_q    <= 1'b0;
            os_q    <= 1'b0;
            armed_q <= 1'b0;
        end else if (we) begin
            // A rewrite in the same cycle as a one-shot hit re-arms it.
            match_q <= cfg_val;
            en_q    <= cfg_en;
            os_q    <= cfg_os;
            armed_q <= 1'b1;
        end else if (os_q && hit && adv) begin
            armed_q <= 1'b0;
        end
    end

endmodule

// File: rtl/tia_lfsr_sequencer.sv
// Parametrised XNOR-feedback LFSR with programmable period and N decode
// channels (periodic or one-shot) for generating timing strobes.
// Ports:
//   clk, rstl            clock, async active-low reset
//   adv                  advance enable (state holds when low)
//   rsyn                 synchronous restart to state 0 (wins over adv)
//   cfg_we/ch/val/en/os  channel configuration write
//   state                current LFSR state
//   wrap                 high while state is the terminal state
//   hit                  per-channel decode strobes
module tia_lfsr_sequencer
    import tia_lfsr_pkg::*;
#(
    parameter int           W      = TIA_W,
    parameter logic [W-1:0] TAPS   = W'(TIA_TAPS),
    parameter int           PERIOD = TIA_PERIOD,
    parameter int           N      = 6,
    localparam int          CW     = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rstl,
    input  logic          adv,
    input  logic          rsyn,
    input  logic          cfg_we,
    input  logic [CW-1:0] cfg_ch,
    input  logic [W-1:0]  cfg_val,
    input  logic          cfg_en,
    input  logic          cfg_os,
    output logic [W-1:0]  state,
    output logic          wrap,
    output logic [N-1:0]  hit
);

    localparam logic [15:0]  TERM16 = lfsr_step(W, 16'(TAPS), PERIOD - 1);
    localparam logic [W-1:0] TERM   = TERM16[W-1:0];

    // A TAPS/PERIOD pair that revisits 0 early would give a shorter cycle
    // than requested, so refuse to elaborate it.
    generate
        if (!period_ok(W, 16'(TAPS), PERIOD) || (N < 1) || (N > 16)) begin : g_cfg_bad
            $fatal(1, "tia_lfsr_sequencer: unsupported W/TAPS/PERIOD/N");
        end
    endgenerate

    logic [W-1:0] state_q;
    logic [W-1:0] state_nxt;

    assign state     = state_q;
    assign wrap      = (state_q == TERM);
    assign state_nxt = {state_q[W-2:0], ~^(state_q & TAPS)};

    always_ff @(posedge clk or negedge rstl) begin
        if (!rstl) begin
            state_q <= '0;
        end else if (rsyn) begin
            state_q <= '0;
        end else if (adv) begin
            state_q <= wrap ? '0 : state_nxt;
        end
    end

    generate
        for (genvar i = 0; i < N; i++) begin : g_ch
            tia_lfsr_channel #(.W(W)) u_ch (
                .clk     (clk),
                .rstl    (rstl),
                .we      (cfg_we && (cfg_ch == CW'(i))),
                .cfg_val (cfg_val),
                .cfg_en  (cfg_en),
                .cfg_os  (cfg_os),
                .adv     (adv),
                .state   (state_q),
                .hit     (hit[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_tia_lfsr_sequencer.sv
module tb_tia_lfsr_sequencer;
    import tia_lfsr_pkg::*;

    localparam int           W      = TIA_W;
    localparam logic [W-1:0] TAPS   = TIA_TAPS;
    localparam int           PERIOD = TIA_PERIOD;
    localparam int           N      = 6;
    localparam int           CW     = (N > 1) ? $clog2(N) : 1;

    logic          clk, rstl, adv, rsyn, cfg_we, cfg_en, cfg_os;
    logic [CW-1:0] cfg_ch;
    logic [W-1:0]  cfg_val, state;
    logic          wrap;
    logic [N-1:0]  hit;

    int checks = 0;
    int failures = 0;

    // Reference model: position in the sequence as a step index, channels
    // as plain arrays.
    int           mk;
    logic [W-1:0] m_match [N];
    logic [N-1:0] m_en, m_os, m_armed;

    tia_lfsr_sequencer #(.W(W), .TAPS(TAPS), .PERIOD(PERIOD), .N(N)) dut (
        .clk(clk), .rstl(rstl), .adv(adv), .rsyn(rsyn), .cfg_we(cfg_we),
        .cfg_ch(cfg_ch), .cfg_val(cfg_val), .cfg_en(cfg_en), .cfg_os(cfg_os),
        .state(state), .wrap(wrap), .hit(hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] seq(input int k);
        logic [15:0] s;
        s = lfsr_step(W, 16'(TAPS), k);
        return s[W-1:0];
    endfunction

    function automatic logic [N-1:0] model_hit();
        logic [N-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++)
            r[i] = m_en[i] & m_armed[i] & (m_match[i] == seq(mk));
        return r;
    endfunction

    task automatic model_reset();
        mk = 0; m_en = '0; m_os = '0; m_armed = '0;
        for (int i = 0; i < N; i++) m_match[i] = '0;
    endtask

    // One clock with the given adv/rsyn (plus any pending cfg write);
    // returns at posedge+1 with the model updated.
    task automatic tick(input logic a, input logic r);
        logic [N-1:0] h;
        adv = a; rsyn = r;
        h = model_hit();
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            if (cfg_we && cfg_ch == CW'(i)) begin
                m_match[i] = cfg_val; m_en[i] = cfg_en; m_os[i] = cfg_os; m_armed[i] = 1'b1;
            end else if (m_os[i] && h[i] && a) begin
                m_armed[i] = 1'b0;
            end
        end
        if (r) mk = 0;
        else if (a) mk = (mk == PERIOD - 1) ? 0 : mk + 1;
        #1;
        cfg_we = 1'b0; adv = 1'b0; rsyn = 1'b0;
    endtask

    task automatic write(input int ch, input logic [W-1:0] v, input logic en,
                         input logic os, input logic a);
        cfg_we = 1'b1; cfg_ch = CW'(ch); cfg_val = v; cfg_en = en; cfg_os = os;
        tick(a, 1'b0);
    endtask

    task automatic test_reset();
        rstl = 1'b0; adv = 1'b0; rsyn = 1'b0; cfg_we = 1'b0;
        cfg_ch = '0; cfg_val = '0; cfg_en = 1'b0; cfg_os = 1'b0;
        #2;
        checks++; if (state !== '0) begin failures++; $display("FAIL reset_state got=%h exp=0", state); end
        checks++; if (wrap !== 1'b0) begin failures++; $display("FAIL reset_wrap got=%b exp=0", wrap); end
        checks++; if (hit !== '0) begin failures++; $display("FAIL reset_hit got=%b exp=0", hit); end
        @(negedge clk);
        rstl = 1'b1;
        model_reset();
    endtask

    task automatic test_free_run();
        int wraps = 0;
        for (int k = 1; k <= 2 * PERIOD; k++) begin
            tick(1'b1, 1'b0);
            if (wrap === 1'b1) wraps++;
            checks++; if (state !== seq(k % PERIOD)) begin failures++; $display("FAIL free_state k=%0d got=%h exp=%h", k, state, seq(k % PERIOD)); end
            checks++; if (wrap !== ((k % PERIOD) == PERIOD - 1)) begin failures++; $display("FAIL free_wrap k=%0d got=%b", k, wrap); end
            checks++; if (hit !== '0) begin failures++; $display("FAIL free_hit k=%0d got=%b exp=0", k, hit); end
        end
        checks++; if (wraps != 2) begin failures++; $display("FAIL free_wrap_count got=%0d exp=2", wraps); end
    endtask

    task automatic test_periodic();
        int stp [6] = '{4, 8, 12, 16, 18, 36};
        int cnt [6] = '{0, 0, 0, 0, 0, 0};
        logic [N-1:0] e;
        for (int i = 0; i < 6; i++) write(i, seq(stp[i]), 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1);
        for (int k = 1; k <= 2 * PERIOD; k++) begin
            tick(1'b1, 1'b0);
            e = '0;
            for (int i = 0; i < 6; i++) e[i] = ((k % PERIOD) == stp[i]);
            for (int i = 0; i < 6; i++) if (hit[i] === 1'b1) cnt[i]++;
            checks++; if (hit !== e) begin failures++; $display("FAIL periodic_hit k=%0d got=%b exp=%b", k, hit, e); end
        end
        for (int i = 0; i < 6; i++) begin
            checks++; if (cnt[i] != 2) begin failures++; $display("FAIL periodic_count ch=%0d got=%0d exp=2", i, cnt[i]); end
        end
    endtask

    task automatic test_oneshot();
        int cnt = 0;
        int at = -1;
        write(2, seq(10), 1'b1, 1'b1, 1'b0);
        tick(1'b0, 1'b1);
        for (int k = 1; k <= 2 * PERIOD; k++) begin
            tick(1'b1, 1'b0);
            if (hit[2] === 1'b1) begin cnt++; at = k; end
            checks++; if (hit !== model_hit()) begin failures++; $display("FAIL oneshot_hit k=%0d got=%b exp=%b", k, hit, model_hit()); end
        end
        checks++; if (cnt != 1 || at != 10) begin failures++; $display("FAIL oneshot_once got=%0d@%0d exp=1@10", cnt, at); end
        write(2, seq(10), 1'b1, 1'b1, 1'b0);
        for (int k = 1; k <= PERIOD; k++) begin
            tick(1'b1, 1'b0);
            checks++; if (hit[2] !== (k == 10)) begin failures++; $display("FAIL oneshot_rearm k=%0d got=%b exp=%b", k, hit[2], k == 10); end
        end
        // Rewrite on the very edge the one-shot fires: it must stay armed.
        write(2, seq(10), 1'b1, 1'b1, 1'b0);
        for (int k = 1; k <= 10; k++) tick(1'b1, 1'b0);
        checks++; if (hit[2] !== 1'b1) begin failures++; $display("FAIL oneshot_pre got=%b exp=1", hit[2]); end
        write(2, seq(10), 1'b1, 1'b1, 1'b1);
        for (int k = 1; k <= PERIOD - 1; k++) tick(1'b1, 1'b0);
        checks++; if (hit[2] !== 1'b1) begin failures++; $display("FAIL oneshot_write_wins got=%b exp=1", hit[2]); end
    endtask

    task automatic test_rsyn();
        tick(1'b0, 1'b1);
        for (int k = 1; k <= 30; k++) tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        checks++; if (state !== '0) begin failures++; $display("FAIL rsyn30_state got=%h exp=0", state); end
        for (int k = 1; k <= PERIOD; k++) begin
            tick(1'b1, 1'b0);
            checks++; if (state !== seq(k % PERIOD)) begin failures++; $display("FAIL rsyn_state k=%0d got=%h exp=%h", k, state, seq(k % PERIOD)); end
            checks++; if (wrap !== (k == PERIOD - 1)) begin failures++; $display("FAIL rsyn_wrap k=%0d got=%b", k, wrap); end
            checks++; if (hit !== model_hit()) begin failures++; $display("FAIL rsyn_hit k=%0d got=%b exp=%b", k, hit, model_hit()); end
        end
        for (int k = 1; k <= PERIOD - 1; k++) tick(1'b1, 1'b0);
        checks++; if (wrap !== 1'b1) begin failures++; $display("FAIL rsyn_at_term got=%b exp=1", wrap); end
        tick(1'b1, 1'b1);
        checks++; if (state !== '0 || wrap !== 1'b0) begin failures++; $display("FAIL rsyn56 got=%h/%b exp=0/0", state, wrap); end
        tick(1'b1, 1'b0);
        checks++; if (state !== seq(1)) begin failures++; $display("FAIL rsyn56_next got=%h exp=%h", state, seq(1)); end
    endtask

    task automatic test_hold();
        for (int pass = 0; pass < 2; pass++) begin
            write(1, seq(8), 1'b1, pass[0], 1'b0);
            tick(1'b0, 1'b1);
            for (int k = 1; k <= 8; k++) tick(1'b1, 1'b0);
            for (int j = 0; j < 5; j++) begin
                tick(1'b0, 1'b0);
                checks++; if (state !== seq(8)) begin failures++; $display("FAIL hold_state p=%0d j=%0d got=%h exp=%h", pass, j, state, seq(8)); end
                checks++; if (hit[1] !== 1'b1) begin failures++; $display("FAIL hold_hit p=%0d j=%0d got=%b exp=1", pass, j, hit[1]); end
            end
            tick(1'b1, 1'b0);
            checks++; if (hit[1] !== 1'b0 || state !== seq(9)) begin failures++; $display("FAIL hold_release p=%0d got=%b/%h", pass, hit[1], state); end
            for (int k = 1; k <= PERIOD - 1; k++) tick(1'b1, 1'b0);
            checks++; if (hit[1] !== (pass == 0)) begin failures++; $display("FAIL hold_next_period p=%0d got=%b exp=%b", pass, hit[1], pass == 0); end
        end
    endtask

    task automatic test_reset_mid();
        tick(1'b0, 1'b1);
        for (int k = 1; k <= PERIOD - 1; k++) tick(1'b1, 1'b0);
        #2 rstl = 1'b0;
        #1;
        checks++; if (state !== '0) begin failures++; $display("FAIL rstmid_state got=%h exp=0", state); end
        checks++; if (wrap !== 1'b0) begin failures++; $display("FAIL rstmid_wrap got=%b exp=0", wrap); end
        checks++; if (hit !== '0) begin failures++; $display("FAIL rstmid_hit got=%b exp=0", hit); end
        model_reset();
        #2 rstl = 1'b1;
        for (int k = 1; k <= 2 * PERIOD; k++) begin
            tick(1'b1, 1'b0);
            checks++; if (hit !== '0 || state !== seq(k % PERIOD)) begin failures++; $display("FAIL rstmid_after k=%0d got=%b/%h", k, hit, state); end
        end
    endtask

    task automatic test_random();
        logic a, r;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 4) == 0) begin
                cfg_we  = 1'b1;
                cfg_ch  = CW'($urandom_range(0, (1 << CW) - 1));
                cfg_val = ($urandom_range(0, 3) != 0) ? seq($urandom_range(0, PERIOD - 1)) : W'($urandom);
                cfg_en  = ($urandom_range(0, 5) != 0);
                cfg_os  = $urandom_range(0, 1) == 1;
            end
            a = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 23) == 0);
            tick(a, r);
            checks++; if (state !== seq(mk)) begin failures++; $display("FAIL rand_state c=%0d got=%h exp=%h", c, state, seq(mk)); end
            checks++; if (wrap !== (mk == PERIOD - 1)) begin failures++; $display("FAIL rand_wrap c=%0d got=%b", c, wrap); end
            checks++; if (hit !== model_hit()) begin failures++; $display("FAIL rand_hit c=%0d got=%b exp=%b", c, hit, model_hit()); end
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_periodic();
        test_oneshot();
        test_rsyn();
        test_hold();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tia_lfsr_sequencer.md
# tia_lfsr_sequencer

Parametrised successor to the TIA horizontal LFSR and its fixed decoder. It is a W-bit XNOR-feedback LFSR with a parameter-selected period and N run-time-programmable decode channels, each with a periodic or one-shot mode. It sits beside the horizontal/vertical timing logic and generates programmable strobes such as blank, sync and counter enables without a new hard-wired decoder per use.

## Interface
Parameters:
- W, 6, LFSR width in bits (3..16).
- TAPS, 6'b110000, feedback mask; feedback bit = XNOR of all state bits selected by TAPS.
- PERIOD, 57, states per cycle (2..2^W-1).
- N, 6, number of decode channels (1..16).

Ports:
- clk  in  1  system clock; everything is rising-edge.
- rstl  in  1  asynchronous, active-low reset.
- adv  in  1  advance enable; state holds when low.
- rsyn  in  1  synchronous restart to state 0.
- cfg_we  in  1  channel configuration write strobe.
- cfg_ch  in  max(1,$clog2(N))  channel index for the write.
- cfg_val  in  W  match state for the written channel.
- cfg_en  in  1  channel enable.
- cfg_os  in  1  one-shot mode (1) or periodic mode (0).
- state  out  W  current LFSR state.
- wrap  out  1  high while state equals the terminal state.
- hit  out  N  per-channel decode strobe.

## Operation
- Step function: next = {state[W-2:0], ~^(state & TAPS)}.
- The terminal state is T = lfsr_step(PERIOD-1), meaning the state reached after PERIOD-1 steps from 0.
- State update priority, evaluated each clock:
  - rsyn = 1: state becomes 0. This wins over adv.
  - else adv = 1 and state == T: state becomes 0.
  - else adv = 1: state becomes next.
  - else: state holds.
- Elaboration check: lfsr_step(k) != 0 for every 1 <= k < PERIOD. Any other PERIOD/TAPS combination is a fatal error.
- Each channel holds registers match[W], en, os and armed.
- A cfg_we write loads match, en and os, and sets armed = 1. An out-of-range cfg_ch is ignored.
- hit[i] = en[i] & armed[i] & (state == match[i]). It is combinational from registers, so it is glitch-free per clock.
- One-shot channel: on any clock edge where hit[i] = 1 and adv = 1, armed[i] clears. The channel stays silent until it is rewritten.
- Periodic channel: armed is never cleared by a hit.
- A match value that is never visited (not in the sequence) never hits. This is legal.
- More than one channel may hit in the same cycle.

## Timing
- Reset values: state = 0, every match = 0, en = 0, os = 0, armed = 0. Therefore hit = 0 and wrap = 0.
- Reset is asynchronous on assertion. Release is synchronous to the first clk edge with rstl high.
- Reset mid-sequence discards all configuration.
- state changes one clock after an adv/rsyn sample. With adv held high the period is exactly PERIOD cycles.
- A configuration write takes effect on the clock after cfg_we. If a one-shot channel is rewritten in the same cycle as its hit, the write wins and armed = 1.
- rsyn asserted while state == T: state becomes 0. No extra wrap cycle is produced.
- With adv low, hit and wrap stay asserted for as long as the matching state is held. A one-shot channel does not disarm while adv is low.

## Structure
- Package tia_lfsr_pkg holds:
  - the function lfsr_step(width, taps, n), used at elaboration for T and by the bench;
  - the default TIA constants: W = 6, TAPS = 6'b110000, PERIOD = 57.
- The only sub-module is tia_lfsr_channel, one per channel. It contains the match, en, os and armed registers, the compare, and the hit logic.
- The top level contains the LFSR register, the wrap compare, the write decode and a generate loop over the N channels.

## Test plan
- Reset, then adv = 1 for 114 cycles, no configuration:
  - state equals lfsr_step(k mod 57) at cycle k;
  - wrap is high only at k = 56 and k = 113;
  - hit = 0 throughout.
- Write channels 0..5 as periodic with matches lfsr_step(4), lfsr_step(8), lfsr_step(12), lfsr_step(16), lfsr_step(18), lfsr_step(36), then run two periods:
  - each hit[i] is high for exactly one cycle per period, at the step matching its channel;
  - every other cycle shows hit = 0.
- Channel 2 one-shot with match lfsr_step(10):
  - hit[2] fires once at step 10 and is silent in the second period;
  - rewriting the channel produces a hit at step 10 of the following period.
- Pulse rsyn at step 30: state is 0 on the next cycle, and wrap and channel hits then follow the sequence restarted from step 0. Also pulse rsyn together with adv at step 56: state becomes 0.
- Hold adv low at step 8 for 5 cycles with channel 1 periodic at lfsr_step(8):
  - hit[1] and state hold for all 5 cycles;
  - rerun with the channel one-shot: it disarms only after adv returns high.
- Drop rstl mid-period:
  - state, hit and wrap go to 0 immediately, without waiting for a clock;
  - after release, previously programmed channels stay silent.
